ber_checker: RTL
================

Name: ber_checker

Overview:
- Receive-side consumer of the BER control flags.
- Buffers the locally regenerated PRBS9 reference bits.
- During the synchronization phase, evaluates every candidate delay of 0..PRBS_LEN-1 against the received bit stream, one 511-symbol window per delay, and keeps the delay with the fewest errors.
- During the counting phase, accumulates total received bits and bit errors at that best delay. The results are exported for readout.

Parameters:
- PRBS_LEN, 511: PRBS period; number of candidate delays and symbols per window.
- ADDR_BITS, 9: width of the delay/tap index, equal to $clog2(PRBS_LEN).
- WIN_ERR_BITS, 9: width of the per-window error accumulator; holds 0..PRBS_LEN.
- CNT_BITS, 64: width of the BER bit and error counters.

Ports:
- clk  input  1  system clock
- i_reset  input  1  asynchronous, active-high reset
- i_ctrl  input  1  symbol strobe at BR rate; all state advances only when this is high
- i_start_synchro  input  1  synchronization phase active
- i_prbs_cmp_curr_addr_done  input  1  current symbol is the last (511th) symbol of the current delay window
- i_start_ber_counter  input  1  counting phase active; stays high
- i_ref_bit  input  1  reference PRBS9 bit for the current symbol
- i_rx_bit  input  1  received, decided bit for the current symbol
- o_sync_done  output  1  best delay is frozen and the counting phase is running
- o_best_delay  output  ADDR_BITS  selected delay
- o_min_err  output  WIN_ERR_BITS  error count of the best window
- o_bit_count  output  CNT_BITS  symbols counted during the counting phase
- o_err_count  output  CNT_BITS  errors counted during the counting phase

Behaviour:

Reset (async, i_reset=1):
- All outputs are 0, except o_min_err, which is all-ones.
- Tap buffer, r_addr and r_win_err are cleared.
- Reset applied mid-operation aborts everything. The sync sweep restarts from delay 0 at the next i_start_synchro.

Tap structure:
- Shift register r_buf[PRBS_LEN-2:0]. On each i_ctrl=1: r_buf <= {r_buf[PRBS_LEN-3:0], i_ref_bit}.
- Tap 0 is i_ref_bit. Tap k (k≥1) is r_buf[k-1], i.e. the reference bit from k strobes earlier.
- Delay d means rx(n) is compared against ref(n-d).
- Per-symbol mismatch: mis = i_rx_bit ^ tap(sel).
- sel is r_addr during the sync phase and o_best_delay during the counting phase. The tap mux is combinational and compared in the same cycle; there is no added latency.

States (2-bit FSM, updated only on i_ctrl=1, except reset):
- IDLE:
  - Waits for i_start_synchro=1, then goes to SYNC.
  - The buffer still shifts while in IDLE so it is full before sync begins.
  - The first strobe with i_start_synchro=1 is already processed as window symbol 0 of delay 0.
- SYNC:
  - Each strobe: r_win_err += mis.
  - On a strobe with i_prbs_cmp_curr_addr_done=1:
    - Compute tot = r_win_err + mis.
    - If tot < o_min_err (strict), set o_min_err <= tot and o_best_delay <= r_addr.
    - Clear r_win_err to 0.
    - r_addr increments and wraps from PRBS_LEN-1 to 0.
  - Ties keep the earlier, lower delay.
  - Goes to COUNT when i_start_ber_counter=1 is seen with i_start_synchro=0.
  - If i_start_synchro drops without i_start_ber_counter, goes back to IDLE and keeps its results.
- COUNT:
  - o_sync_done=1.
  - Each strobe: o_bit_count += 1 and o_err_count += mis.
  - Both counters saturate at all-ones and never wrap.
  - Stays in COUNT until reset.

Other rules:
- i_ctrl=0: all registers hold.
- A done flag seen outside SYNC is ignored.
- An expected mis-combination of flags (synchro and ber_counter both high) is treated as SYNC.
- Outputs are registered; values update on the clock edge after the qualifying strobe.

Decomposition:
- Shared package ber_pkg holds:
  - PRBS_LEN=511
  - PRBS9 polynomial (x^9+x^5+1) and seed constant
  - state enum {IDLE, SYNC, COUNT}
  - a shared ADDR_BITS localparam used by both ber_control and ber_checker
- One natural sub-module, ber_tap_buffer: the shift register plus combinational tap mux (ports: clk, i_reset, i_ctrl, i_bit, i_sel, o_tap).
- The FSM and counters stay in ber_checker.

Test Plan:
1. Error-free delay:
   - Stimulus: rx = ref delayed 37 strobes, error-free; drive the flags exactly as ber_control does (START_SYN small, e.g. 1000).
   - Required response: o_best_delay=37, o_min_err=0, o_sync_done=1. After 10000 counting strobes, o_bit_count=10000 and o_err_count=0.
2. Injected errors:
   - Stimulus: rx = ref delayed 200, with 1 bit flipped every 100 symbols.
   - Required response: o_best_delay=200, o_min_err ∈ {5,6}. Error count over 51100 counting symbols = 511.
3. Stall handling:
   - Stimulus: i_ctrl toggled with a pattern of 1 strobe per 4 clocks (OS=4).
   - Required response: results identical to test 1; registers are unchanged on clocks where i_ctrl=0.
4. Reset mid-sync:
   - Stimulus: assert i_reset at window 300 of the sweep, then release and restart the flags.
   - Required response: all outputs return to their reset values immediately, asynchronously, without waiting for a clock. The rerun finds the same best delay.
5. Tie-break and saturation:
   - Stimulus: rx constant 0.
   - Required response for tie-break: o_best_delay is the lowest delay among those tied at the minimum.
   - Stimulus: CNT_BITS=4 with rx inverted during COUNT.
   - Required response for saturation: o_bit_count and o_err_count stick at 15.

Source files
------------

// File: rtl/ber_pkg.sv
// Shared constants, state encoding and PRBS9 helper for the BER receive path.
package ber_pkg;

    localparam int unsigned PRBS_LEN     = 511;
    localparam int unsigned ADDR_BITS    = $clog2(PRBS_LEN);
    localparam int unsigned WIN_ERR_BITS = $clog2(PRBS_LEN + 1);
    localparam int unsigned CNT_BITS     = 64;

    localparam int unsigned PRBS9_ORDER = 9;
    // x^9 + x^5 + 1: feedback taps at bit 8 and bit 4 of the state
    localparam logic [PRBS9_ORDER-1:0] PRBS9_POLY = 9'h110;
    localparam logic [PRBS9_ORDER-1:0] PRBS9_SEED = 9'h1FF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        COUNT = 2'd2
    } ber_state_e;

    function automatic logic [PRBS9_ORDER-1:0] prbs9_step(input logic [PRBS9_ORDER-1:0] s);
        return {s[PRBS9_ORDER-2:0], ^(s & PRBS9_POLY)};
    endfunction

endpackage

// File: rtl/ber_checker_if.sv
// Control flags, symbol bits and exported BER results of the checker.
interface ber_checker_if
    import ber_pkg::*;
#(
    parameter int unsigned P_ADDR_BITS    = ADDR_BITS,
    parameter int unsigned P_WIN_ERR_BITS = WIN_ERR_BITS,
    parameter int unsigned P_CNT_BITS     = CNT_BITS
);

    logic                      i_ctrl;
    logic                      i_start_synchro;
    logic                      i_prbs_cmp_curr_addr_done;
    logic                      i_start_ber_counter;
    logic                      i_ref_bit;
    logic                      i_rx_bit;
    logic                      o_sync_done;
    logic [P_ADDR_BITS-1:0]    o_best_delay;
    logic [P_WIN_ERR_BITS-1:0] o_min_err;
    logic [P_CNT_BITS-1:0]     o_bit_count;
    logic [P_CNT_BITS-1:0]     o_err_count;

    modport master (
        output i_ctrl, i_start_synchro, i_prbs_cmp_curr_addr_done, i_start_ber_counter,
        output i_ref_bit, i_rx_bit,
        input  o_sync_done, o_best_delay, o_min_err, o_bit_count, o_err_count
    );

    modport slave (
        input  i_ctrl, i_start_synchro, i_prbs_cmp_curr_addr_done, i_start_ber_counter,
        input  i_ref_bit, i_rx_bit,
        output o_sync_done, o_best_delay, o_min_err, o_bit_count, o_err_count
    );

endinterface

// File: rtl/ber_tap_buffer.sv
// Reference-bit delay line; tap k returns the reference bit from k strobes earlier.
module ber_tap_buffer
    import ber_pkg::*;
#(
    parameter int unsigned P_LEN = PRBS_LEN,
    parameter int unsigned P_AW  = $clog2(P_LEN)
) (
    input  logic            clk,
    input  logic            i_reset,
    input  logic            i_ctrl,
    input  logic            i_bit,
    input  logic [P_AW-1:0] i_sel,
    output logic            o_tap
);

    logic [P_LEN-2:0] r_buf;
    logic [P_LEN-1:0] w_taps;

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            r_buf <= '0;
        end else if (i_ctrl) begin
            r_buf <= {r_buf[P_LEN-3:0], i_bit};
        end
    end

    // Tap 0 is the live input so delay 0 compares with no added latency
    assign w_taps = {r_buf, i_bit};
    assign o_tap  = w_taps[i_sel];

endmodule

// File: rtl/ber_checker.sv
// Sweeps every candidate delay for the fewest window errors, then counts bits/errors at that delay.
module ber_checker
    import ber_pkg::*;
#(
    parameter int unsigned P_PRBS_LEN = PRBS_LEN,
    parameter int unsigned P_CNT_BITS = CNT_BITS
) (
    input  logic         clk,
    input  logic         i_reset,
    ber_checker_if.slave bus
);

    localparam int unsigned AW = $clog2(P_PRBS_LEN);
    localparam int unsigned EW = $clog2(P_PRBS_LEN + 1);
    localparam int unsigned CW = P_CNT_BITS;

    ber_state_e      r_state;
    ber_state_e      w_state_nxt;
    logic [AW-1:0]   r_addr;
    logic [EW-1:0]   r_win_err;
    logic            r_sync_done;
    logic [AW-1:0]   r_best_delay;
    logic [EW-1:0]   r_min_err;
    logic [CW-1:0]   r_bit_count;
    logic [CW-1:0]   r_err_count;
    logic [AW-1:0]   w_sel;
    logic            w_tap;
    logic            w_mis;
    logic            w_sync_work;
    logic [EW-1:0]   w_tot;

    assign w_sel = (r_state == COUNT) ? r_best_delay : r_addr;

    ber_tap_buffer #(
        .P_LEN (P_PRBS_LEN),
        .P_AW  (AW)
    ) u_tap (
        .clk     (clk),
        .i_reset (i_reset),
        .i_ctrl  (bus.i_ctrl),
        .i_bit   (bus.i_ref_bit),
        .i_sel   (w_sel),
        .o_tap   (w_tap)
    );

    assign w_mis = bus.i_rx_bit ^ w_tap;
    assign w_tot = r_win_err + EW'(w_mis);
    // The strobe that raises synchro in IDLE is already symbol 0 of delay 0
    assign w_sync_work = (r_state == SYNC) || ((r_state == IDLE) && bus.i_start_synchro);

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else if (bus.i_ctrl) begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (bus.i_start_synchro) w_state_nxt = SYNC;
            SYNC:    if (!bus.i_start_synchro) w_state_nxt = bus.i_start_ber_counter ? COUNT : IDLE;
            COUNT:   w_state_nxt = COUNT;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Window accumulation and strict-minimum tracking; ties keep the lower delay
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            r_addr       <= '0;
            r_win_err    <= '0;
            r_best_delay <= '0;
            r_min_err    <= '1;
        end else if (bus.i_ctrl && w_sync_work) begin
            if (bus.i_prbs_cmp_curr_addr_done) begin
                r_win_err <= '0;
                r_addr    <= (r_addr == AW'(P_PRBS_LEN - 1)) ? '0 : r_addr + AW'(1);
                if (w_tot < r_min_err) begin
                    r_min_err    <= w_tot;
                    r_best_delay <= r_addr;
                end
            end else begin
                r_win_err <= w_tot;
            end
        end
    end

    // Saturating BER counters
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            r_sync_done <= 1'b0;
            r_bit_count <= '0;
            r_err_count <= '0;
        end else if (bus.i_ctrl) begin
            r_sync_done <= (w_state_nxt == COUNT);
            if (r_state == COUNT) begin
                if (r_bit_count != '1) r_bit_count <= r_bit_count + CW'(1);
                if (w_mis && (r_err_count != '1)) r_err_count <= r_err_count + CW'(1);
            end
        end
    end

    assign bus.o_sync_done  = r_sync_done;
    assign bus.o_best_delay = r_best_delay;
    assign bus.o_min_err    = r_min_err;
    assign bus.o_bit_count  = r_bit_count;
    assign bus.o_err_count  = r_err_count;

endmodule
